// File: rtl/phase_index_generator_if.sv
// Control/status bundle between the phase index generator and its controller.
// The master drives tuning and waveform requests; the slave returns index/f/wrap/pending.
interface phase_index_generator_if #(
    parameter int ACC_W = 24
);
    logic             enable;
    logic             restart;
    logic [ACC_W-1:0] tw_in;
    logic             tw_load;
    logic [1:0]       f_in;
    logic [7:0]       index;
    logic [1:0]       f;
    logic             wrap;
    logic             pending;

    modport master (
        output enable, restart, tw_in, tw_load, f_in,
        input  index, f, wrap, pending
    );

    modport slave (
        input  enable, restart, tw_in, tw_load, f_in,
        output index, f, wrap, pending
    );
endinterface

// File: rtl/phase_index_generator.sv
// Phase accumulator feeding the waveform block: index = accumulator MSBs, f = active waveform.
// Tuning words are staged until a phase wrap; define PHASE_TW_IMMEDIATE_EN to apply them at once.
module phase_index_generator #(
    parameter int ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    phase_index_generator_if.slave bus
);
    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] tw_active_q, tw_active_d;
    logic [ACC_W-1:0] tw_shadow_q, tw_shadow_d;
    logic [1:0]       f_q, f_d;
    logic             wrap_q, wrap_d;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             armed;

    // The extra MSB of the sum is the phase-wrap carry.
    assign sum   = {1'b0, acc_q} + {1'b0, tw_active_q};
    assign carry = sum[ACC_W];
    assign armed = (state_q == ARMED);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d     = state_q;
        acc_d       = acc_q;
        tw_active_d = tw_active_q;
        tw_shadow_d = tw_shadow_q;
        f_d         = f_q;
        wrap_d      = 1'b0;

        if (bus.restart) begin
            acc_d = '0;
            f_d   = bus.f_in;
            if (bus.tw_load) begin
                tw_shadow_d = bus.tw_in;
                tw_active_d = bus.tw_in;
            end else if (armed) begin
                tw_active_d = tw_shadow_q;
            end
            state_d = bus.enable ? RUNNING : STOPPED;
        end else if (!bus.enable) begin
            // Not running, so nothing can glitch: settings apply straight away and a staged word is flushed.
            state_d = STOPPED;
            f_d     = bus.f_in;
            if (bus.tw_load) begin
                tw_shadow_d = bus.tw_in;
                tw_active_d = bus.tw_in;
            end else if (armed) begin
                tw_active_d = tw_shadow_q;
            end
        end else begin
            acc_d   = sum[ACC_W-1:0];
            wrap_d  = carry;
            state_d = armed ? ARMED : RUNNING;
            if (carry) begin
                f_d = bus.f_in;
                if (armed) begin
                    tw_active_d = tw_shadow_q;
                    state_d     = RUNNING;
                end
            end
            // A load on the wrap edge still re-arms; the carry above consumed the older shadow.
            if (bus.tw_load) begin
`ifdef PHASE_TW_IMMEDIATE_EN
                tw_shadow_d = bus.tw_in;
                tw_active_d = bus.tw_in;
`else
                tw_shadow_d = bus.tw_in;
                state_d     = ARMED;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STOPPED;
            acc_q       <= '0;
            tw_active_q <= '0;
            tw_shadow_q <= '0;
            f_q         <= 2'b00;
            wrap_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q     <= state_d;
            acc_q       <= acc_d;
            tw_active_q <= tw_active_d;
            tw_shadow_q <= tw_shadow_d;
            f_q         <= f_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.index   = acc_q[ACC_W-1 -: 8];
    assign bus.f       = f_q;
    assign bus.wrap    = wrap_q;
    assign bus.pending = armed;
endmodule
